// File: rtl/ef_spi_slave.sv
// ef_spi_slave: SPI slave with one-word rx holding register and one-word tx buffer.
// All SPI pins are synchronized into clk_i; sclk must run at or below clk_i/4.
// Default build: SPI mode 0 only. Define EF_SPI_SLAVE_MODE_SEL_EN to add cpol/cpha
// inputs and support SPI modes 0-3.
//
// Ports
//   clk_i, rst_i          system clock, synchronous active-high reset
//   sclk, csb, mosi       SPI inputs (asynchronous to clk_i)
//   miso, miso_oe         SPI serial out and its drive enable
//   rx_data, rx_valid     last received word and its valid flag
//   rx_rd                 pop pulse, clears rx_valid
//   rx_ovr                sticky: a word arrived while rx_valid was still set
//   ovr_clr               clears rx_ovr and tx_udr
//   tx_data, tx_wr        word for the next transfer and its write pulse
//   tx_full               tx buffer holds a word
//   tx_udr                sticky: a word was shifted out with the buffer empty
//   busy                  chip select active
//   cpol, cpha            SPI mode select (EF_SPI_SLAVE_MODE_SEL_EN only)
module ef_spi_slave #(
    parameter int unsigned DW = 8
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          sclk,
    input  logic          csb,
    input  logic          mosi,
    output logic          miso,
    output logic          miso_oe,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_rd,
    output logic          rx_ovr,
    input  logic          ovr_clr,
    input  logic [DW-1:0] tx_data,
    input  logic          tx_wr,
    output logic          tx_full,
    output logic          tx_udr,
    output logic          busy
`ifdef EF_SPI_SLAVE_MODE_SEL_EN
    ,
    input  logic          cpol,
    input  logic          cpha
`endif
);

    localparam int unsigned CW = $clog2(DW);

    typedef enum logic {
        ST_IDLE,
        ST_ACTIVE
    } state_t;

    state_t          state_q, state_nxt;
    logic [1:0]      sclk_sync, csb_sync, mosi_sync;
    logic            sclk_prev, csb_prev;
    logic [1:0]      sync_fill;
    logic            csb_armed;
    logic [CW-1:0]   bit_cnt;
    logic [DW-1:0]   rx_sr, tx_sr, tx_buf;
    logic            reload_pend;

    logic            mode_cpol, mode_cpha;
    logic            sclk_rise, sclk_fall, lead_e, trail_e, sample_e, shift_e;
    logic            csb_fall, csb_rise;
    logic            start, in_word, do_sample, do_shift, do_load, word_done;
    logic [DW-1:0]   load_word, rx_word;

`ifdef EF_SPI_SLAVE_MODE_SEL_EN
    assign mode_cpol = cpol;
    assign mode_cpha = cpha;
`else
    assign mode_cpol = 1'b0;
    assign mode_cpha = 1'b0;
`endif

    // Input synchronizers and edge-detect history. csb_armed blocks a false
    // falling edge when csb is already low as reset releases.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= 2'b00;
            csb_sync  <= 2'b11;
            mosi_sync <= 2'b00;
            sclk_prev <= 1'b0;
            csb_prev  <= 1'b1;
            sync_fill <= 2'b00;
            csb_armed <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[0], sclk};
            csb_sync  <= {csb_sync[0], csb};
            mosi_sync <= {mosi_sync[0], mosi};
            sclk_prev <= sclk_sync[1];
            csb_prev  <= csb_sync[1];
            sync_fill <= {sync_fill[0], 1'b1};
            csb_armed <= csb_armed | (sync_fill[1] & csb_sync[1]);
        end
    end

    // Edge strobes: leading edge leaves the idle level, cpha picks which one samples.
    always_comb begin
        sclk_rise = sclk_sync[1] & ~sclk_prev;
        sclk_fall = ~sclk_sync[1] & sclk_prev;
        lead_e    = mode_cpol ? sclk_fall : sclk_rise;
        trail_e   = mode_cpol ? sclk_rise : sclk_fall;
        sample_e  = mode_cpha ? trail_e : lead_e;
        shift_e   = mode_cpha ? lead_e : trail_e;
        csb_fall  = csb_armed & csb_prev & ~csb_sync[1];
        csb_rise  = ~csb_prev & csb_sync[1];
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_nxt;
    end

    // Next state and datapath strobes
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            ST_IDLE:   if (csb_fall) state_nxt = ST_ACTIVE;
            ST_ACTIVE: if (csb_rise) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
        start     = (state_q == ST_IDLE) && (state_nxt == ST_ACTIVE);
        in_word   = (state_q == ST_ACTIVE) && (state_nxt == ST_ACTIVE);
        do_sample = in_word & sample_e;
        do_shift  = in_word & shift_e;
        do_load   = start | (do_shift & reload_pend);
        load_word = tx_full ? tx_buf : '0;
        word_done = do_sample && (bit_cnt == CW'(DW - 1));
        rx_word   = {rx_sr[DW-2:0], mosi_sync[1]};
    end

    // Shift registers, buffers and status flags
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            miso        <= 1'b0;
            miso_oe     <= 1'b0;
            busy        <= 1'b0;
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            rx_ovr      <= 1'b0;
            tx_full     <= 1'b0;
            tx_udr      <= 1'b0;
            tx_buf      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            bit_cnt     <= '0;
            reload_pend <= 1'b0;
        end else begin
            miso_oe <= (state_nxt == ST_ACTIVE);
            busy    <= (state_nxt == ST_ACTIVE);

            // Receive side; a word boundary arms the tx reload for the next shift edge.
            if (!in_word) begin
                bit_cnt     <= '0;
                reload_pend <= 1'b0;
            end else if (do_sample) begin
                rx_sr   <= rx_word;
                bit_cnt <= word_done ? '0 : bit_cnt + CW'(1);
                if (word_done) reload_pend <= 1'b1;
            end else if (do_shift) begin
                reload_pend <= 1'b0;
            end

            // Transmit side; with cpha=1 the MSB first appears on the leading edge.
            if (state_nxt == ST_IDLE) begin
                tx_sr <= '0;
                miso  <= 1'b0;
            end else if (start) begin
                tx_sr <= mode_cpha ? load_word : {load_word[DW-2:0], 1'b0};
                miso  <= mode_cpha ? 1'b0 : load_word[DW-1];
            end else if (do_shift) begin
                if (reload_pend) begin
                    tx_sr <= {load_word[DW-2:0], 1'b0};
                    miso  <= load_word[DW-1];
                end else begin
                    tx_sr <= {tx_sr[DW-2:0], 1'b0};
                    miso  <= tx_sr[DW-1];
                end
            end

            // tx buffer: a load consumes it; writes are accepted only when empty and not loading.
            if (ovr_clr) tx_udr <= 1'b0;
            if (do_load) begin
                if (tx_full) tx_full <= 1'b0;
                else         tx_udr  <= 1'b1;
            end else if (tx_wr && !tx_full) begin
                tx_buf  <= tx_data;
                tx_full <= 1'b1;
            end

            // rx holding register; a simultaneous pop and new word keeps rx_valid without overrun.
            if (ovr_clr) rx_ovr   <= 1'b0;
            if (rx_rd)   rx_valid <= 1'b0;
            if (word_done) begin
                rx_data  <= rx_word;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_rd) rx_ovr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ef_spi_slave.sv
// tb_ef_spi_slave: directed bench for ef_spi_slave acting as an SPI master.
// Define EF_SPI_SLAVE_MODE_SEL_EN for both files to include the mode-3 case.
module tb_ef_spi_slave;

    localparam int unsigned DW = 8;
    localparam int HP = 8;   // SPI half period in clk cycles

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          sclk = 1'b0, csb = 1'b1, mosi = 1'b0;
    logic          miso, miso_oe;
    logic [DW-1:0] rx_data;
    logic          rx_valid, rx_ovr, tx_full, tx_udr, busy;
    logic          rx_rd = 1'b0, ovr_clr = 1'b0, tx_wr = 1'b0;
    logic [DW-1:0] tx_data = '0;
`ifdef EF_SPI_SLAVE_MODE_SEL_EN
    logic          cpol = 1'b0, cpha = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    ef_spi_slave #(.DW(DW)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .sclk    (sclk),
        .csb     (csb),
        .mosi    (mosi),
        .miso    (miso),
        .miso_oe (miso_oe),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_rd   (rx_rd),
        .rx_ovr  (rx_ovr),
        .ovr_clr (ovr_clr),
        .tx_data (tx_data),
        .tx_wr   (tx_wr),
        .tx_full (tx_full),
        .tx_udr  (tx_udr),
        .busy    (busy)
`ifdef EF_SPI_SLAVE_MODE_SEL_EN
        ,
        .cpol    (cpol),
        .cpha    (cpha)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tx_wr(input logic [DW-1:0] d);
        tx_data = d;
        tx_wr   = 1'b1;
        wait_clks(1);
        tx_wr   = 1'b0;
        wait_clks(1);
    endtask

    task automatic pop();
        rx_rd = 1'b1;
        wait_clks(1);
        rx_rd = 1'b0;
        wait_clks(1);
    endtask

    task automatic clear_flags();
        ovr_clr = 1'b1;
        wait_clks(1);
        ovr_clr = 1'b0;
        wait_clks(1);
    endtask

    task automatic csb_start();
        csb = 1'b0;
        wait_clks(HP);
    endtask

    task automatic csb_end();
        wait_clks(HP);
        csb = 1'b1;
        wait_clks(2 * HP);
    endtask

    // Clock nbits of one word MSB first; sampling edge is leading for cpha=0, trailing for cpha=1.
    task automatic spi_bits(input logic [7:0] tx, input int nbits, input logic cp, input logic ph,
                            output logic [7:0] rx);
        rx = '0;
        for (int i = 0; i < nbits; i++) begin
            if (!ph) begin
                mosi = tx[7-i];
                wait_clks(HP);
                sclk = ~cp;
                rx   = {rx[6:0], miso};
                wait_clks(HP);
                sclk = cp;
            end else begin
                wait_clks(HP);
                sclk = ~cp;
                mosi = tx[7-i];
                wait_clks(HP);
                sclk = cp;
                rx   = {rx[6:0], miso};
            end
        end
    endtask

    task automatic xfer(input logic [7:0] tx, input logic cp, input logic ph, output logic [7:0] rx);
        csb_start();
        spi_bits(tx, 8, cp, ph, rx);
        csb_end();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] m_rx, m_rx2;

        // Reset values
        wait_clks(3);
        check("rst_miso_oe", miso_oe, 0);
        check("rst_busy", busy, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_full", tx_full, 0);
        rst_i = 1'b0;
        wait_clks(4);

        // Basic mode-0 exchange; second write while full is dropped
        pulse_tx_wr(8'hA5);
        check("tx_full_set", tx_full, 1);
        pulse_tx_wr(8'hFF);
        xfer(8'h3C, 1'b0, 1'b0, m_rx);
        check("m0_master_rx", m_rx, 8'hA5);
        check("m0_rx_data", rx_data, 8'h3C);
        check("m0_rx_valid", rx_valid, 1);
        check("m0_tx_full", tx_full, 0);
        check("m0_busy_after", busy, 0);
        pop();
        check("pop_rx_valid", rx_valid, 0);

        // Back-to-back words without a pop -> overrun
        csb_start();
        spi_bits(8'h11, 8, 1'b0, 1'b0, m_rx);
        spi_bits(8'h22, 8, 1'b0, 1'b0, m_rx2);
        csb_end();
        check("b2b_rx_data", rx_data, 8'h22);
        check("b2b_rx_ovr", rx_ovr, 1);
        check("b2b_master_w1", m_rx, 8'h00);
        check("b2b_master_w2", m_rx2, 8'h00);
        clear_flags();
        check("ovr_clr_rx_ovr", rx_ovr, 0);
        check("ovr_clr_tx_udr", tx_udr, 0);
        check("ovr_clr_rx_valid", rx_valid, 1);
        pop();

        // Empty tx buffer -> zeros and underrun
        xfer(8'h55, 1'b0, 1'b0, m_rx);
        check("udr_master_rx", m_rx, 8'h00);
        check("udr_tx_udr", tx_udr, 1);
        check("udr_rx_data", rx_data, 8'h55);
        pop();

        // Partial word is discarded
        csb_start();
        spi_bits(8'hFF, 5, 1'b0, 1'b0, m_rx);
        csb_end();
        check("part_rx_valid", rx_valid, 0);
        check("part_busy", busy, 0);
        pulse_tx_wr(8'h42);
        xfer(8'h81, 1'b0, 1'b0, m_rx);
        check("after_part_rx_data", rx_data, 8'h81);
        check("after_part_master_rx", m_rx, 8'h42);
        check("after_part_rx_ovr", rx_ovr, 0);
        pop();

        // Reset mid-word
        csb_start();
        pulse_tx_wr(8'h77);
        spi_bits(8'hF0, 4, 1'b0, 1'b0, m_rx);
        wait_clks(4);
        check("mid_busy", busy, 1);
        check("mid_miso_oe", miso_oe, 1);
        check("mid_tx_full", tx_full, 1);
        rst_i = 1'b1;
        wait_clks(1);
        check("mrst_miso", miso, 0);
        check("mrst_miso_oe", miso_oe, 0);
        check("mrst_rx_data", rx_data, 0);
        check("mrst_rx_valid", rx_valid, 0);
        check("mrst_rx_ovr", rx_ovr, 0);
        check("mrst_tx_full", tx_full, 0);
        check("mrst_tx_udr", tx_udr, 0);
        check("mrst_busy", busy, 0);
        rst_i = 1'b0;
        wait_clks(20);
        check("mrst_no_rearm", busy, 0);
        csb = 1'b1;
        wait_clks(2 * HP);
        xfer(8'h5A, 1'b0, 1'b0, m_rx);
        check("post_rst_rx_data", rx_data, 8'h5A);
        check("post_rst_rx_valid", rx_valid, 1);
        check("post_rst_master_rx", m_rx, 8'h00);
        pop();

`ifdef EF_SPI_SLAVE_MODE_SEL_EN
        // Mode 3
        cpol = 1'b1;
        cpha = 1'b1;
        sclk = 1'b1;
        wait_clks(HP);
        pulse_tx_wr(8'h96);
        xfer(8'hC3, 1'b1, 1'b1, m_rx);
        check("m3_rx_data", rx_data, 8'hC3);
        check("m3_master_rx", m_rx, 8'h96);
        check("m3_rx_valid", rx_valid, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ef_spi_slave.md
EF_SPI_SLAVE -- requirements
Module: ef_spi_slave

Interface
REQ-001 The block SHALL have exactly one clock and a synchronous, active-high reset: clk_i (all logic on its rising edge) and rst_i.
REQ-002 Parameter: DW, 8, word width in bits (legal 8, 16, 32).
REQ-003 Port: clk_i  in  1  system clock.
REQ-004 Port: rst_i  in  1  synchronous active-high reset.
REQ-005 Ports: sclk in 1 SPI clock; csb in 1 active-low chip select; mosi in 1 serial in; miso out 1 serial out; miso_oe out 1 miso drive enable.
REQ-006 Ports: rx_data out DW received word; rx_valid out 1 word held; rx_rd in 1 pop pulse; rx_ovr out 1 sticky overrun; ovr_clr in 1 clears rx_ovr.
REQ-007 Ports: tx_data in DW word to send; tx_wr in 1 write pulse; tx_full out 1 tx buffer occupied; tx_udr out 1 sticky underrun (cleared by ovr_clr); busy out 1 transfer in progress.

Function
REQ-008 sclk, csb, mosi SHALL pass through 2-flop synchronizers; edges are detected on the synchronized signals; sclk frequency SHALL be at most clk_i/4.
REQ-009 States: IDLE (csb high, miso_oe=0, bit counter=0) and ACTIVE (csb low, miso_oe=1, busy=1).
REQ-010 IDLE->ACTIVE on the synchronized csb falling edge; ACTIVE->IDLE on the synchronized csb rising edge.
REQ-011 On IDLE->ACTIVE: tx shift register loads tx buffer if tx_full=1 (tx_full clears), else loads all-zeros and sets tx_udr; miso = shift MSB.
REQ-012 Mode 0: mosi sampled on sclk rising edge (shift in MSB first); miso advances on sclk falling edge.
REQ-013 Bit counter SHALL increment per sampling edge and wrap from DW-1 to 0.
REQ-014 On the DW-th sampling edge: rx_data <= assembled word and rx_valid <= 1, visible the next clk_i cycle; if rx_valid was already 1 and rx_rd not asserted in that cycle, rx_ovr <= 1 and rx_data is overwritten.
REQ-015 On the shifting edge following a word boundary, tx shift register reloads per REQ-011 rule (buffer or zeros+tx_udr).
REQ-016 rx_rd clears rx_valid next cycle; rx_rd with new word in the same cycle: rx_valid stays 1, no overrun.
REQ-017 tx_wr with tx_full=0 loads buffer, tx_full<=1; tx_wr with tx_full=1 is ignored; tx_wr in the same cycle as a load is ignored.
REQ-018 csb rising mid-word: partial word discarded, no rx_valid, counter=0, tx shift content discarded (buffer untouched).
REQ-019 sclk edges while IDLE SHALL be ignored.

Reset
REQ-020 rst_i high at a clock edge: state IDLE; miso=0, miso_oe=0, rx_data=0, rx_valid=0, rx_ovr=0, tx_full=0, tx_udr=0, busy=0, synchronizers to idle levels (csb=1, sclk=0).
REQ-021 Reset during ACTIVE aborts the transfer with no rx_valid; ACTIVE re-entered only on a fresh csb falling edge.

Configuration
REQ-022 Macro EF_SPI_SLAVE_MODE_SEL_EN: defined -> input ports cpol and cpha (1 bit each) added, sampling/shifting edges per SPI modes 0-3, cpha=1 presents MSB on first leading edge instead of csb fall; undefined -> ports absent, mode 0 fixed.

Verification
REQ-023 tx_wr tx_data=0xA5, then master mode-0 transfer sending 0x3C -> master receives 0xA5; rx_data=0x3C, rx_valid=1; tx_full=0.
REQ-024 Two back-to-back words 0x11, 0x22 without rx_rd -> rx_data=0x22, rx_ovr=1; ovr_clr -> rx_ovr=0.
REQ-025 Transfer with tx_full=0 -> master receives 0x00, tx_udr=1.
REQ-026 csb raised after 5 bits -> rx_valid stays 0; next full transfer of 0x81 -> rx_data=0x81.
REQ-027 rst_i asserted mid-word -> all outputs at REQ-020 values next cycle; following transfer of 0x5A received intact.
REQ-028 With EF_SPI_SLAVE_MODE_SEL_EN, cpol=1 cpha=1, send 0xC3 with tx 0x96 -> rx_data=0xC3, master receives 0x96.
